// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter that drives the select of a downstream
// 4:1 data mux and produces the valid/last side of its handshake.
//
// A channel is granted for a burst of up to MAX_BURST beats. sel and gnt only
// change at reset or at a grant boundary, so the mux output is a clean
// per-channel stream. After each grant the channel just served becomes the
// lowest priority.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   req[3:0]   per-channel request (bit i = channel i has data)
//   out_ready  downstream accepts a beat this cycle
//   sel[1:0]   mux select, binary index of the granted channel
//   gnt[3:0]   one-hot grant, zero when idle
//   out_valid  beat on the mux output is valid
//   last       current beat is the final beat of the burst
module rr_sel_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       last
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic       xfer;
  logic       grant_end;
  logic [1:0] search_base;
  logic [1:0] cand;
  logic [1:0] win_idx;
  logic       win_found;

  // Handshake outputs are combinational so a dropped request is seen the same cycle.
  always_comb begin
    out_valid = (state_q == StGrant) & req[sel_q];
    last      = out_valid & (beat_cnt_q == LastCnt);
    xfer      = out_valid & out_ready;
    grant_end = (state_q == StGrant) & ((xfer & last) | ~req[sel_q]);
  end

  // Rotating priority search. In IDLE start at ptr; at a grant boundary start
  // just after the channel being released, which makes it lowest priority.
  always_comb begin
    search_base = (state_q == StIdle) ? ptr_q : sel_q + 2'd1;
    win_found   = 1'b0;
    win_idx     = search_base;
    cand        = search_base;
    // Walk backwards so the closest requester to search_base is written last.
    for (int k = 3; k >= 0; k--) begin
      cand = search_base + 2'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StGrant;
          sel_d      = win_idx;
          gnt_d      = 4'b0001 << win_idx;
          beat_cnt_d = '0;
        end
      end
      StGrant: begin
        if (grant_end) begin
          ptr_d = sel_q + 2'd1;
          if (win_found) begin
            // Back-to-back grant, no idle bubble.
            sel_d      = win_idx;
            gnt_d      = 4'b0001 << win_idx;
            beat_cnt_d = '0;
          end else begin
            // sel keeps its last value while idle.
            state_d    = StIdle;
            gnt_d      = 4'b0000;
            beat_cnt_d = '0;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      ptr_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel = sel_q;
  assign gnt = gnt_q;

endmodule
